// File: rtl/qed_consistency_checker.sv
// Writeback-side QED checker: pairs original-stream register writes (x1-x15) with
// their duplicate-stream twins (x17-x31) and latches the first inconsistency seen.
module qed_consistency_checker #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     commit_vld,
    input  logic                     commit_is_dup,
    input  logic                     wb_en,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    output logic                     qed_ready,
    output logic                     qed_check_fail,
    output logic [2:0]               err_code,
    output logic [CNT_W-1:0]         orig_cnt,
    output logic [CNT_W-1:0]         dup_cnt,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      PEND_ONE = 1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_NO_ORIG    = 3'd1,
        ERR_DATA       = 3'd2,
        ERR_WRONG_HALF = 3'd3,
        ERR_OVERFLOW   = 3'd4,
        ERR_RD         = 3'd5
    } err_e;

    logic [35:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    err_e             err_q;
    err_e             err_new;
    err_e             code_nxt;
    logic             ev;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             err_det;
    logic             fail_nxt;
    logic             ready_nxt;
    logic [3:0]       rd_lo;
    logic [35:0]      head;
    logic [AW:0]      pend_nxt;
    logic [CNT_W-1:0] orig_nxt;
    logic [CNT_W-1:0] dup_nxt;

    assign ev       = ena & commit_vld;
    assign full     = (pending == FULL_LVL);
    assign empty    = (pending == '0);
    assign rd_lo    = wb_rd[3:0];
    assign head     = mem[rd_ptr];
    assign err_code = err_q;

    // Classify the retiring write; x0 and its twin x16 never enter the pairing.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        err_det = 1'b0;
        err_new = ERR_NONE;
        if (ev && wb_en) begin
            if (!commit_is_dup) begin
                if (wb_rd[4]) begin
                    err_det = 1'b1;
                    err_new = ERR_WRONG_HALF;
                end else if (rd_lo != 4'd0) begin
                    if (full) begin
                        err_det = 1'b1;
                        err_new = ERR_OVERFLOW;
                    end else begin
                        push = 1'b1;
                    end
                end
            end else begin
                if (wb_rd[4] && rd_lo != 4'd0) begin
                    if (empty) begin
                        err_det = 1'b1;
                        err_new = ERR_NO_ORIG;
                    end else begin
                        pop = 1'b1;
                        if (head[35:32] != rd_lo) begin
                            err_det = 1'b1;
                            err_new = ERR_RD;
                        end else if (head[31:0] != wb_data) begin
                            err_det = 1'b1;
                            err_new = ERR_DATA;
                        end
                    end
                end else if (!wb_rd[4] && rd_lo != 4'd0) begin
                    err_det = 1'b1;
                    err_new = ERR_WRONG_HALF;
                end
            end
        end
    end

    // Next-state values; qed_ready is derived from these so it moves with the counters.
    always_comb begin
        orig_nxt = orig_cnt;
        dup_nxt  = dup_cnt;
        pend_nxt = pending;
        code_nxt = err_q;
        if (ev && !commit_is_dup && orig_cnt != '1)
            orig_nxt = orig_cnt + CNT_ONE;
        if (ev && commit_is_dup && dup_cnt != '1)
            dup_nxt = dup_cnt + CNT_ONE;
        if (push)
            pend_nxt = pending + PEND_ONE;
        else if (pop)
            pend_nxt = pending - PEND_ONE;
        if (!qed_check_fail && err_det)
            code_nxt = err_new;
        fail_nxt  = qed_check_fail | err_det;
        ready_nxt = (orig_nxt == dup_nxt) & (orig_nxt != '0) & (pend_nxt == '0) & ~fail_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pending        <= '0;
            orig_cnt       <= '0;
            dup_cnt        <= '0;
            qed_check_fail <= 1'b0;
            qed_ready      <= 1'b0;
            err_q          <= ERR_NONE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            pending        <= pend_nxt;
            orig_cnt       <= orig_nxt;
            dup_cnt        <= dup_nxt;
            qed_check_fail <= fail_nxt;
            qed_ready      <= ready_nxt;
            err_q          <= code_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {rd_lo, wb_data};
    end

endmodule
